// File: rtl/rf_wb_scheduler_if.sv
// Write-back sources, register file write port and decode scoreboard lookups for rf_wb_scheduler.
// master = execute/decode side driving beats and queries, slave = the scheduler.
interface rf_wb_scheduler_if #(
    parameter int NSRC = 3
);
    logic [NSRC-1:0]      src_valid;
    logic [5*NSRC-1:0]    src_rd;
    logic [32*NSRC-1:0]   src_data;
    logic [NSRC-1:0]      src_ready;

    logic                 rf_we;
    logic [4:0]           rf_rd_addr;
    logic [31:0]          rf_rd_data;

    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_ready;

    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;

    modport master (
        output src_valid, src_rd, src_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  src_ready, rf_we, rf_rd_addr, rf_rd_data, issue_ready, rs1_busy, rs2_busy
    );

    modport slave (
        input  src_valid, src_rd, src_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
        output src_ready, rf_we, rf_rd_addr, rf_rd_data, issue_ready, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Register file write-back arbiter + pending-write scoreboard; aging promotion under RF_WB_AGING_EN.
// Latency: accept in N, rf_we in N+1, busy bit clear from N+2; one write per cycle.
// Backpressure: src_ready one-hot grant from src_valid and registered state only; issue_ready low while rd pending.
module rf_wb_scheduler #(
    parameter int NSRC       = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_scheduler_if.slave  bus
);
    if (NSRC < 1 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("rf_wb_scheduler: NSRC must be >= 1 and STARVE_MAX within 1..15");
    end

    logic [NSRC-1:0] grant;
    logic            acc_vld;
    logic [4:0]      acc_rd;
    logic [31:0]     acc_dat;
    logic            found;

    logic            we_q;
    logic [4:0]      addr_q;
    logic [31:0]     data_q;

    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            issue_ok;

`ifdef RF_WB_AGING_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] wait_cnt [NSRC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (!bus.src_valid[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != STARVE_LIM) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end
        end
    end
`endif

    // Starved sources (aging build) win first, then plain lowest-index priority.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        acc_rd  = '0;
        acc_dat = '0;
`ifdef RF_WB_AGING_EN
        for (int i = 0; i < NSRC; i++) begin
            if (!found && bus.src_valid[i] && wait_cnt[i] == STARVE_LIM) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NSRC; i++) begin
            if (!found && bus.src_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!rst_n) grant = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                acc_rd  = bus.src_rd[5*i +: 5];
                acc_dat = bus.src_data[32*i +: 32];
            end
        end
    end

    assign acc_vld       = |grant;
    assign bus.src_ready = grant;

    // Beats to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= acc_vld && (acc_rd != 5'd0);
            if (acc_vld && acc_rd != 5'd0) begin
                addr_q <= acc_rd;
                data_q <= acc_dat;
            end
        end
    end

    assign bus.rf_we      = we_q;
    assign bus.rf_rd_addr = addr_q;
    assign bus.rf_rd_data = data_q;

    assign issue_ok        = !busy[bus.issue_rd] || (bus.issue_rd == 5'd0);
    assign bus.issue_ready = rst_n && issue_ok;

    always_comb begin
        busy_nxt = busy;
        if (we_q) busy_nxt[addr_q] = 1'b0;
        if (bus.issue_valid && bus.issue_ready && bus.issue_rd != 5'd0) begin
            busy_nxt[bus.issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign bus.rs1_busy = busy[bus.rs1_addr];
    assign bus.rs2_busy = busy[bus.rs2_addr];
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: a reference model predicts grants, writes and busy bits.
module tb_rf_wb_scheduler;
    localparam int NSRC       = 3;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_scheduler_if #(.NSRC(NSRC)) bus ();

    rf_wb_scheduler #(.NSRC(NSRC), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stimulus state owned by the bench
    logic [NSRC-1:0] sv;
    logic [4:0]      srd  [NSRC];
    logic [31:0]     sdat [NSRC];
    logic            iv;
    logic [4:0]      ird, r1, r2;

    // Reference model
    int              mcnt [NSRC];
    logic [31:0]     mbusy;
    logic            m_we;
    logic [4:0]      m_addr;
    logic [36:0]     exp_q [$];
    int              last_g;

    int n_chk  = 0;
    int n_pass = 0;
    int rdy1_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            bus.src_valid[i]          = sv[i];
            bus.src_rd[5*i +: 5]      = srd[i];
            bus.src_data[32*i +: 32]  = sdat[i];
        end
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.rs1_addr    = r1;
        bus.rs2_addr    = r2;
    endtask

    task automatic reset_model();
        m_we   = 1'b0;
        m_addr = '0;
        mbusy  = '0;
        for (int i = 0; i < NSRC; i++) mcnt[i] = 0;
        exp_q.delete();
    endtask

    function automatic int model_grant();
        int g = -1;
`ifdef RF_WB_AGING_EN
        for (int i = 0; i < NSRC; i++)
            if (g < 0 && sv[i] && mcnt[i] == STARVE_MAX) g = i;
`endif
        for (int i = 0; i < NSRC; i++)
            if (g < 0 && sv[i]) g = i;
        if (!rst_n) g = -1;
        return g;
    endfunction

    // One clock: check combinational outputs, advance the model, check the registered write.
    task automatic run_cycle();
        logic [NSRC-1:0] exp_rdy;
        logic            iss_ok;
        logic [36:0]     e;
        int              g;
        drive();
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("src_ready", 32'(bus.src_ready), 32'(exp_rdy));
        rdy1_seen += int'(bus.src_ready[1]);
        iss_ok = !mbusy[ird] || (ird == 5'd0);
        check_eq("issue_ready", 32'(bus.issue_ready), 32'(iss_ok));
        check_eq("rs1_busy", 32'(bus.rs1_busy), 32'(mbusy[r1]));
        check_eq("rs2_busy", 32'(bus.rs2_busy), 32'(mbusy[r2]));

        for (int i = 0; i < NSRC; i++) begin
            if (!sv[i] || i == g) mcnt[i] = 0;
            else if (mcnt[i] < STARVE_MAX) mcnt[i]++;
        end
        if (m_we) mbusy[m_addr] = 1'b0;
        if (iv && iss_ok && ird != 5'd0) mbusy[ird] = 1'b1;
        m_we = 1'b0;
        if (g >= 0 && srd[g] != 5'd0) begin
            m_we   = 1'b1;
            m_addr = srd[g];
            exp_q.push_back({srd[g], sdat[g]});
        end
        last_g = g;

        @(posedge clk);
        #1;
        check_eq("rf_we", 32'(bus.rf_we), 32'(m_we));
        if (bus.rf_we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rf_rd_addr", 32'(bus.rf_rd_addr), 32'(e[36:32]));
            check_eq("rf_rd_data", bus.rf_rd_data, e[31:0]);
        end
        if (last_g >= 0) sv[last_g] = 1'b0;
    endtask

    initial begin
        #100000;
        $fatal(1, "watchdog expired before the summary line");
    end

    initial begin
        int exp_seen;
        rdy1_seen = 0;
        sv = '0;
        for (int i = 0; i < NSRC; i++) begin
            srd[i]  = '0;
            sdat[i] = '0;
        end
        iv = 1'b0; ird = 5'd5; r1 = '0; r2 = '0;
        reset_model();

        // Reset: valid sources must not be granted while rst_n is low
        sv = 3'b101; srd[0] = 5'd3; srd[2] = 5'd4;
        drive();
        #2;
        check_eq("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check_eq("rst_addr", 32'(bus.rf_rd_addr), 32'd0);
        check_eq("rst_data", bus.rf_rd_data, 32'd0);
        check_eq("rst_src_ready", 32'(bus.src_ready), 32'd0);
        check_eq("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        check_eq("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        sv = '0;
        drive();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run_cycle();

        // Two sources at once: 0 first, 2 next, back-to-back writes
        sv[0] = 1'b1; srd[0] = 5'd3; sdat[0] = 32'h11;
        sv[2] = 1'b1; srd[2] = 5'd4; sdat[2] = 32'h22;
        run_cycle();
        run_cycle();
        run_cycle();

        // Source 1 held off by continuous source 0 traffic
        rdy1_seen = 0;
        sv[1] = 1'b1; srd[1] = 5'd6; sdat[1] = 32'h66;
        for (int k = 0; k < 8; k++) begin
            sv[0] = 1'b1; srd[0] = 5'd2; sdat[0] = 32'h100 + 32'(k);
            run_cycle();
        end
`ifdef RF_WB_AGING_EN
        exp_seen = 1;
`else
        exp_seen = 0;
`endif
        check_eq("starved_grants", 32'(rdy1_seen), 32'(exp_seen));
        for (int k = 0; k < 4 && sv[1]; k++) run_cycle();
        run_cycle();

        // Long-latency issue to x7, then its write-back clears the scoreboard
        iv = 1'b1; ird = 5'd7; r1 = 5'd7; r2 = 5'd3;
        run_cycle();
        iv = 1'b0;
        run_cycle();
        iv = 1'b1;
        run_cycle();
        iv = 1'b0;
        sv[2] = 1'b1; srd[2] = 5'd7; sdat[2] = 32'hDEAD;
        run_cycle();
        run_cycle();
        run_cycle();

        // Write to x0 is consumed and dropped; issue to x0 always accepted
        sv[1] = 1'b1; srd[1] = 5'd0; sdat[1] = 32'hFFFF;
        iv = 1'b1; ird = 5'd0; r1 = 5'd0; r2 = 5'd7;
        run_cycle();
        iv = 1'b0;
        run_cycle();

        // Reset with a registered beat and a pending entry
        iv = 1'b1; ird = 5'd9; r1 = 5'd9; r2 = 5'd9;
        run_cycle();
        iv = 1'b0;
        sv[0] = 1'b1; srd[0] = 5'd9; sdat[0] = 32'h99;
        run_cycle();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
        check_eq("mid_rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check_eq("mid_rst_rs2_busy", 32'(bus.rs2_busy), 32'd0);
        check_eq("mid_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cycle();
        run_cycle();
        check_eq("post_rst_addr", 32'(bus.rf_rd_addr), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
